mult32x32_req_if: RTL and testbench
===================================

Name: mult32x32_req_if

Overview:
Request/response front end for the 32x32 sequential multiplier.
- Accepts operand pairs on a valid/ready interface and holds them in a one-entry operand buffer.
- Launches the multiplier with a one-cycle start pulse and keeps its A/B operands stable for the whole operation.
- Captures the 64-bit product in the single cycle it is valid, then presents it on a valid/ready result interface with backpressure.
- Sits directly upstream of the multiplier FSM/datapath (drives start, consumes busy and product) and is the block system logic talks to.

Parameters:
MAX_WAIT, 8, number of WAIT cycles without busy falling before a timeout is declared (must be >= 5)
CNT_W, 16, width of the completed-operation counter

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  operand buffer can accept
in_a  input  32  multiplicand
in_b  input  32  multiplier
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_product  output  64  registered product
mul_start  output  1  start pulse to multiplier
mul_a  output  32  registered operand A to multiplier
mul_b  output  32  registered operand B to multiplier
mul_busy  input  1  multiplier busy
mul_product  input  64  multiplier product register
op_count  output  CNT_W  completed operations, wraps modulo 2^CNT_W
err  output  1  sticky timeout flag

Behaviour:
- Reset (reset=0, async): state IDLE, op_full=0, res_full=0, mul_start=0, mul_a=mul_b=0, out_product=0, op_count=0, err=0. Reset mid-operation discards buffered operands and any in-flight result; the multiplier shares the reset.
- in_ready = !op_full (combinational from the register). Handshake in_valid&&in_ready loads the operand buffer and sets op_full.
- States:
  - IDLE: if op_full && !res_full, load mul_a/mul_b from the operand buffer, clear op_full, go to START. Otherwise stay.
  - START: mul_start=1 for exactly this cycle; clear the wait counter; go to WAIT.
  - WAIT: increment the wait counter each cycle. On the first cycle with mul_busy==0, latch mul_product into out_product, set res_full, increment op_count, go to IDLE. Capture must happen in this exact cycle because the multiplier clears its product on the next edge.
  - Timeout: if the counter reaches MAX_WAIT with busy still high, set err (sticky until reset), go to IDLE with no result, and leave op_count unchanged.
- mul_a/mul_b change only in IDLE on load; they are stable from START through the end of WAIT.
- mul_start is never asserted outside START.
- Result interface: out_valid=res_full. Handshake out_valid&&out_ready clears res_full. out_product holds its value until the next capture.
- Only one operation is in flight. A launch requires res_full=0, so capture and drain never collide.
- An operand pair may be accepted while the multiplier is computing (op_full clears at load).
- Latency: handshake in cycle 0; load in cycle 1; START in cycle 2; busy high in cycles 2-6; capture at end of cycle 7; out_valid=1 in cycle 8.
- Simultaneous in handshake and IDLE load: not possible, since load requires op_full=1, which forces in_ready=0.

Optional Feature:
MULT_ZERO_BYPASS_EN
- Defined: in IDLE, if op_full && !res_full and in_a==0 or in_b==0 (as buffered), write out_product=0, set res_full, increment op_count, clear op_full, and stay in IDLE. No mul_start is issued; out_valid rises 2 cycles after the input handshake.
- Undefined: zero operands take the normal 8-cycle multiplier path.

Decomposition:
- Package mult32x32_pkg: state enum (IDLE, START, WAIT), OP_W=32, PROD_W=64.
- No sub-module. The operand buffer, result register and counters are small enough to stay inline.

Test Plan:
1. After reset, a=3, b=5 -> mul_start high for exactly 1 cycle (cycle 2), out_valid=1 with out_product=15 in cycle 8, op_count=1, err=0.
2. a=0xFFFFFFFF, b=0xFFFFFFFF -> out_product=0xFFFFFFFE00000001. mul_a/mul_b stay constant from START through capture.
3. out_ready=0, two pairs sent (2x3, 4x5) -> second pair accepted (in_ready=1 after load) but not launched while the first result is held. After draining 6, the next result is 20 and op_count=2.
4. Multiplier model holds busy=1 -> after 8 WAIT cycles err=1, state IDLE, out_valid stays 0, op_count unchanged. err stays 1 until reset.
5. reset=0 asserted during WAIT (cycle 4) -> all outputs immediately at reset values. A new request afterwards completes normally.
6. a=0, b=7 -> with MULT_ZERO_BYPASS_EN: out_valid in cycle 2, product 0, mul_start never asserted. Without it: normal path, out_valid in cycle 8, product 0.

Source files
------------

// File: rtl/mult32x32_pkg.sv
// Shared types for the 32x32 multiplier request/response front end.
package mult32x32_pkg;

  localparam int OP_W   = 32;
  localparam int PROD_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } op_req_t;

  function automatic logic has_zero(input op_req_t r);
    return (r.a == '0) || (r.b == '0);
  endfunction

endpackage

// File: rtl/mult32x32_req_if.sv
// Valid/ready front end for the sequential 32x32 multiplier: one-entry operand buffer,
// start/capture sequencing, timeout, result holding. Optional macro: MULT_ZERO_BYPASS_EN.
module mult32x32_req_if
  import mult32x32_pkg::*;
#(
  parameter int MAX_WAIT = 8,   // must be >= 5
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_product,
  output logic              mul_start,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  input  logic              mul_busy,
  input  logic [PROD_W-1:0] mul_product,
  output logic [CNT_W-1:0]  op_count,
  output logic              err
);

  localparam int WCNT_W = $clog2(MAX_WAIT + 1);

  state_e              state, state_nxt;
  op_req_t             op_q;
  logic                op_full;
  logic                res_full;
  logic [WCNT_W-1:0]   wait_cnt;
  logic                launch, bypass, capture, timeout;

  assign in_ready  = !op_full;
  assign out_valid = res_full;

  always_comb begin
    bypass = 1'b0;
`ifdef MULT_ZERO_BYPASS_EN
    bypass = (state == IDLE) && op_full && !res_full && has_zero(op_q);
`endif
    launch  = (state == IDLE) && op_full && !res_full && !bypass;
    // The multiplier clears its product on the edge after busy falls, so capture is now-or-never.
    capture = (state == WAIT) && !mul_busy;
    timeout = (state == WAIT) && mul_busy && (wait_cnt == WCNT_W'(MAX_WAIT - 1));
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (capture || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    mul_start = 1'b0;
    if (state == START) mul_start = 1'b1;
  end

  // Operand buffer; load and accept are mutually exclusive since load needs op_full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_full <= 1'b0;
      op_q    <= '0;
    end else if (launch || bypass) begin
      op_full <= 1'b0;
    end else if (in_valid && !op_full) begin
      op_full <= 1'b1;
      op_q    <= '{a: in_a, b: in_b};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_a <= '0;
      mul_b <= '0;
    end else if (launch) begin
      mul_a <= op_q.a;
      mul_b <= op_q.b;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              wait_cnt <= '0;
    else if (state == START) wait_cnt <= '0;
    else if (state == WAIT)  wait_cnt <= wait_cnt + 1'b1;
  end

  // Result register; launch requires !res_full so capture never meets a drain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_full    <= 1'b0;
      out_product <= '0;
    end else if (capture) begin
      res_full    <= 1'b1;
      out_product <= mul_product;
    end else if (bypass) begin
      res_full    <= 1'b1;
      out_product <= '0;
    end else if (res_full && out_ready) begin
      res_full    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_count <= '0;
      err      <= 1'b0;
    end else begin
      if (capture || bypass) op_count <= op_count + 1'b1;
      if (timeout)           err      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mult32x32_req_if.sv
// Bench for mult32x32_req_if: vector table, scoreboard and multi-cycle corner sequences.
module tb_mult32x32_req_if;

`ifdef MULT_ZERO_BYPASS_EN
  localparam int LAT_Z    = 2;
  localparam int STARTS_Z = 0;
`else
  localparam int LAT_Z    = 8;
  localparam int STARTS_Z = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0, in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_product;
  logic        mul_start;
  logic [31:0] mul_a, mul_b;
  logic        mul_busy;
  logic [63:0] mul_product;
  logic [15:0] op_count;
  logic        err;

  mult32x32_req_if #(.MAX_WAIT(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_busy(mul_busy), .mul_product(mul_product),
    .op_count(op_count), .err(err)
  );

  always #5 clk = ~clk;

  // Multiplier model: busy 4 cycles after start, product valid for exactly one cycle.
  logic        mdl_busy, stuck = 1'b0;
  logic [2:0]  mdl_cnt;
  logic [63:0] mdl_res, mdl_prod;
  assign mul_busy    = mdl_busy | stuck;
  assign mul_product = mdl_prod;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mdl_busy <= 1'b0; mdl_cnt <= '0; mdl_res <= '0; mdl_prod <= '0;
    end else if (mul_start) begin
      mdl_busy <= 1'b1; mdl_cnt <= 3'd4; mdl_prod <= '0;
      mdl_res  <= 64'(mul_a) * 64'(mul_b);
    end else if (mdl_busy) begin
      if (mdl_cnt == 3'd1) begin
        mdl_busy <= 1'b0; mdl_prod <= mdl_res;
      end
      mdl_cnt <= mdl_cnt - 3'd1;
    end else begin
      mdl_prod <= '0;
    end
  end

  int n_cmp = 0, n_err = 0;
  logic [63:0] sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset && in_valid && in_ready) sb.push_back(64'(in_a) * 64'(in_b));
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL sb_empty: got result %0h with nothing expected", out_product);
      end else begin
        chk("sb_product", out_product, sb.pop_front());
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0; in_valid = 1'b0; stuck = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    sb.delete();
    #1 reset = 1'b1;
  endtask

  // Sends one pair in cycle 0 and returns at the first cycle with out_valid.
  task automatic run_one(input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_p, input int exp_lat, input int exp_starts);
    int lat, starts;
    logic stable, trk;
    logic [31:0] ma, mb;
    @(posedge clk); #1;
    chk("in_ready_c0", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_a = a; in_b = b;
    lat = 0; starts = 0; stable = 1'b1; trk = 1'b0; ma = '0; mb = '0;
    while (lat < 40) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
      if (mul_start) begin
        starts++; trk = 1'b1; ma = mul_a; mb = mul_b;
        chk("mul_ab", {mul_a, mul_b}, {a, b});
      end else if (trk && (mul_a !== ma || mul_b !== mb)) begin
        stable = 1'b0;
      end
      if (out_valid) break;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("start_pulses", 64'(starts), 64'(exp_starts));
    chk("ab_stable", 64'(stable), 64'd1);
    chk("product", out_product, exp_p);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    int          lat;
  } vec_t;
  vec_t vt[7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int starts;
    logic [31:0] ra, rb;
    vt[0] = '{32'd3,          32'd5,          64'd15,                  8};
    vt[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 8};
    vt[2] = '{32'd7,          32'd6,          64'd42,                  8};
    vt[3] = '{32'h0000_FFFF,  32'h0000_FFFF,  64'h0000_0000_FFFE_0001, 8};
    vt[4] = '{32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000, 8};
    vt[5] = '{32'd1,          32'hFFFF_FFFF,  64'h0000_0000_FFFF_FFFF, 8};
    vt[6] = '{32'd5,          32'd0,          64'd0,                   LAT_Z};

    // Reset state
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_product", out_product, 64'd0);
    chk("rst_start", 64'(mul_start), 64'd0);
    chk("rst_mul_ab", {mul_a, mul_b}, 64'd0);
    chk("rst_cnt_err", {47'd0, err, op_count}, 64'd0);
    do_reset();

    // 1: basic 3x5 with cycle-exact latency
    run_one(32'd3, 32'd5, 64'd15, 8, 1);
    chk("t1_op_count", 64'(op_count), 64'd1);
    chk("t1_err", 64'(err), 64'd0);

    // Vector table + random pairs
    for (int i = 0; i < 7; i++) run_one(vt[i].a, vt[i].b, vt[i].p, vt[i].lat, (vt[i].lat == 8) ? 1 : STARTS_Z);
    for (int i = 0; i < 5; i++) begin
      ra = $urandom; rb = $urandom;
      run_one(ra, rb, 64'(ra) * 64'(rb), (ra == 0 || rb == 0) ? LAT_Z : 8, (ra == 0 || rb == 0) ? STARTS_Z : 1);
    end
    @(posedge clk); #1;

    // 3: backpressure with a second pair buffered
    do_reset();
    out_ready = 1'b0;
    @(posedge clk); #1; in_valid = 1'b1; in_a = 32'd2; in_b = 32'd3;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("t3_start_c2", 64'(mul_start), 64'd1);
    chk("t3_in_ready_c2", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_a = 32'd4; in_b = 32'd5;
    @(posedge clk); #1; in_valid = 1'b0;
    chk("t3_in_ready_c3", 64'(in_ready), 64'd0);
    starts = 0;
    repeat (11) begin
      @(posedge clk); #1;
      if (mul_start) starts++;
    end
    chk("t3_hold_valid", 64'(out_valid), 64'd1);
    chk("t3_hold_product", out_product, 64'd6);
    chk("t3_no_launch", 64'(starts), 64'd0);
    chk("t3_op_count1", 64'(op_count), 64'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_drained", 64'(out_valid), 64'd0);
    for (int i = 0; i < 30 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("t3_second_product", out_product, 64'd20);
    chk("t3_op_count2", 64'(op_count), 64'd2);
    @(posedge clk); #1;

    // 4: timeout with busy stuck high
    do_reset();
    stuck = 1'b1;
    @(posedge clk); #1; in_valid = 1'b1; in_a = 32'd9; in_b = 32'd9;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (c == 10) chk("t4_err_before", 64'(err), 64'd0);
    end
    chk("t4_err_set", 64'(err), 64'd1);
    chk("t4_no_result", 64'(out_valid), 64'd0);
    chk("t4_op_count", 64'(op_count), 64'd0);
    sb.delete();
    stuck = 1'b0;
    starts = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (mul_start) starts++;
    end
    chk("t4_idle_no_start", 64'(starts), 64'd0);
    run_one(32'd2, 32'd2, 64'd4, 8, 1);
    chk("t4_err_sticky", 64'(err), 64'd1);
    chk("t4_op_count_after", 64'(op_count), 64'd1);
    @(posedge clk); #1;

    // 5: reset in the middle of WAIT
    do_reset();
    @(posedge clk); #1; in_valid = 1'b1; in_a = 32'd6; in_b = 32'd7;
    repeat (4) begin
      @(posedge clk); #1; in_valid = 1'b0;
    end
    reset = 1'b0;
    #1;
    chk("t5_out_valid", 64'(out_valid), 64'd0);
    chk("t5_start", 64'(mul_start), 64'd0);
    chk("t5_mul_ab", {mul_a, mul_b}, 64'd0);
    chk("t5_in_ready", 64'(in_ready), 64'd1);
    chk("t5_cnt_err", {47'd0, err, op_count}, 64'd0);
    sb.delete();
    @(posedge clk); #1; reset = 1'b1;
    run_one(32'd6, 32'd7, 64'd42, 8, 1);
    chk("t5_op_count", 64'(op_count), 64'd1);
    @(posedge clk); #1;

    // 6: zero operand
    do_reset();
    run_one(32'd0, 32'd7, 64'd0, LAT_Z, STARTS_Z);
    chk("t6_op_count", 64'(op_count), 64'd1);
    @(posedge clk); #1;
    chk("t6_drained", 64'(out_valid), 64'd0);
    chk("t6_sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
